// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Purpose  : Shared definitions for the pipelined MIPS core. Holds the
//            control-bundle layout, the ALU operation encodings and the
//            bubble (no-op) constants.
// Contents : ctrl_t        packed control bundle
//                          {regwrite, memread, memwrite, memtoreg, alusrc, regdst}
//            CTRL_*        bit indices into the 6-bit control bundle
//            alucon_t      4-bit ALU operation code
//            ALU_*         ALU operation encodings
//            CTRL_BUBBLE   control bundle of an inserted bubble
// Revision : 1.0  initial release
// ============================================================================
package mips_pkg;

  localparam int CTRL_W        = 6;
  localparam int CTRL_REGWRITE = 5;
  localparam int CTRL_MEMREAD  = 4;
  localparam int CTRL_MEMWRITE = 3;
  localparam int CTRL_MEMTOREG = 2;
  localparam int CTRL_ALUSRC   = 1;
  localparam int CTRL_REGDST   = 0;

  typedef struct packed {
    logic regwrite;
    logic memread;
    logic memwrite;
    logic memtoreg;
    logic alusrc;
    logic regdst;
  } ctrl_t;

  typedef logic [3:0] alucon_t;

  localparam alucon_t ALU_NOP = 4'b0000;
  localparam alucon_t ALU_AND = 4'b0000;
  localparam alucon_t ALU_OR  = 4'b0001;
  localparam alucon_t ALU_ADD = 4'b0010;
  localparam alucon_t ALU_SUB = 4'b0110;
  localparam alucon_t ALU_SLT = 4'b0111;

  localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/id_ex_stage_fwd_mux.sv
`default_nettype none
// ============================================================================
// Module   : fwd_mux
// Purpose  : Single-operand forwarding selector. Picks the newest in-flight
//            value of a source register: EX/MEM beats MEM/WB, which beats the
//            value read from the register file. Register 0 never forwards.
// Ports    : reg_i           source register number held in EX
//            regval_i        register-file value captured with it
//            mem_regwrite_i  EX/MEM writes a register
//            mem_rd_i        EX/MEM destination
//            mem_result_i    EX/MEM ALU result
//            wb_regwrite_i   MEM/WB writes a register
//            wb_rd_i         MEM/WB destination
//            wb_result_i     MEM/WB writeback value
//            val_o           forwarded operand
// Revision : 1.0  initial release
// ============================================================================
module fwd_mux #(
  parameter int WIDTH = 32,
  parameter int RA    = 5
) (
  input  logic [RA-1:0]    reg_i,
  input  logic [WIDTH-1:0] regval_i,
  input  logic             mem_regwrite_i,
  input  logic [RA-1:0]    mem_rd_i,
  input  logic [WIDTH-1:0] mem_result_i,
  input  logic             wb_regwrite_i,
  input  logic [RA-1:0]    wb_rd_i,
  input  logic [WIDTH-1:0] wb_result_i,
  output logic [WIDTH-1:0] val_o
);

  logic w_nonzero;
  logic w_hit_mem;
  logic w_hit_wb;

  assign w_nonzero = (reg_i != '0);
  assign w_hit_mem = w_nonzero & mem_regwrite_i & (mem_rd_i == reg_i);
  assign w_hit_wb  = w_nonzero & wb_regwrite_i  & (wb_rd_i  == reg_i);

  always_comb begin
    val_o = regval_i;
    if (w_hit_mem) begin
      val_o = mem_result_i;
    end else if (w_hit_wb) begin
      val_o = wb_result_i;
    end
  end

endmodule : fwd_mux
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Purpose  : ID/EX pipeline register plus EX operand selection. Captures
//            decoded operands/control, forwards from MEM and WB, drives the
//            ALU operands, and detects load-use hazards (one bubble).
// Ports    : id_*            decoded instruction from ID
//            stall           external hold (freezes this register)
//            flush           branch/jump kill (loads a bubble)
//            mem_*, wb_*     forwarding sources
//            SrcA/SrcB       ALU operands, ALUcon registered ALU op
//            ex_store_data   forwarded rt (store data)
//            ex_wreg         selected destination register
//            ex_ctrl         {regwrite, memread, memwrite, memtoreg}
//            ex_valid        EX holds a real instruction
//            hazard_stall    load-use hazard, front end must hold
// Revision : 1.0  initial release
// ============================================================================
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RA    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] id_rd1,
  input  logic [WIDTH-1:0] id_rd2,
  input  logic [WIDTH-1:0] id_imm,
  input  logic [RA-1:0]    id_rs,
  input  logic [RA-1:0]    id_rt,
  input  logic [RA-1:0]    id_rd,
  input  logic [3:0]       id_alucon,
  input  logic [5:0]       id_ctrl,
  input  logic             id_valid,
  input  logic             stall,
  input  logic             flush,
  input  logic             mem_regwrite,
  input  logic [RA-1:0]    mem_rd,
  input  logic [WIDTH-1:0] mem_result,
  input  logic             wb_regwrite,
  input  logic [RA-1:0]    wb_rd,
  input  logic [WIDTH-1:0] wb_result,
  output logic [WIDTH-1:0] SrcA,
  output logic [WIDTH-1:0] SrcB,
  output logic [3:0]       ALUcon,
  output logic [WIDTH-1:0] ex_store_data,
  output logic [RA-1:0]    ex_wreg,
  output logic [3:0]       ex_ctrl,
  output logic             ex_valid,
  output logic             hazard_stall
);

  // regdst is consumed at capture time (wreg selection), so only the upper
  // five control bits are carried into EX.
  localparam int CTRL_Q_W = CTRL_W - 1;

  ctrl_t w_id_ctrl;
  assign w_id_ctrl = ctrl_t'(id_ctrl);

  logic [WIDTH-1:0]    rd1_q,    rd1_d;
  logic [WIDTH-1:0]    rd2_q,    rd2_d;
  logic [WIDTH-1:0]    imm_q,    imm_d;
  logic [RA-1:0]       rs_q,     rs_d;
  logic [RA-1:0]       rt_q,     rt_d;
  logic [RA-1:0]       wreg_q,   wreg_d;
  logic [3:0]          alucon_q, alucon_d;
  logic [CTRL_Q_W-1:0] ctrl_q,   ctrl_d;
  logic                valid_q,  valid_d;

  // ctrl_q bit positions are the bundle indices shifted down by one.
  logic w_ex_memread;
  logic w_ex_alusrc;
  logic w_hazard;

  assign w_ex_memread = ctrl_q[CTRL_MEMREAD - 1];
  assign w_ex_alusrc  = ctrl_q[CTRL_ALUSRC - 1];

  // rt only counts as a source when the instruction does not use the
  // immediate for operand B.
  assign w_hazard = valid_q & w_ex_memread & id_valid & (wreg_q != '0) &
                    ((wreg_q == id_rs) | ((wreg_q == id_rt) & ~w_id_ctrl.alusrc));

  always_comb begin
    rd1_d    = rd1_q;
    rd2_d    = rd2_q;
    imm_d    = imm_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    wreg_d   = wreg_q;
    alucon_d = alucon_q;
    ctrl_d   = ctrl_q;
    valid_d  = valid_q;
    if (flush || (!stall && w_hazard)) begin
      rd1_d    = '0;
      rd2_d    = '0;
      imm_d    = '0;
      rs_d     = '0;
      rt_d     = '0;
      wreg_d   = '0;
      alucon_d = ALU_NOP;
      ctrl_d   = CTRL_BUBBLE[CTRL_W-1:1];
      valid_d  = 1'b0;
    end else if (!stall) begin
      rd1_d    = id_rd1;
      rd2_d    = id_rd2;
      imm_d    = id_imm;
      rs_d     = id_rs;
      rt_d     = id_rt;
      wreg_d   = w_id_ctrl.regdst ? id_rd : id_rt;
      alucon_d = id_alucon;
      ctrl_d   = id_ctrl[CTRL_W-1:1];
      valid_d  = id_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd1_q    <= '0;
      rd2_q    <= '0;
      imm_q    <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      wreg_q   <= '0;
      alucon_q <= ALU_NOP;
      ctrl_q   <= CTRL_BUBBLE[CTRL_W-1:1];
      valid_q  <= 1'b0;
    end else begin
      rd1_q    <= rd1_d;
      rd2_q    <= rd2_d;
      imm_q    <= imm_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      wreg_q   <= wreg_d;
      alucon_q <= alucon_d;
      ctrl_q   <= ctrl_d;
      valid_q  <= valid_d;
    end
  end

  logic [WIDTH-1:0] w_fwd_a;
  logic [WIDTH-1:0] w_fwd_b;

  fwd_mux #(.WIDTH(WIDTH), .RA(RA)) u_fwd_a (
    .reg_i          (rs_q),
    .regval_i       (rd1_q),
    .mem_regwrite_i (mem_regwrite),
    .mem_rd_i       (mem_rd),
    .mem_result_i   (mem_result),
    .wb_regwrite_i  (wb_regwrite),
    .wb_rd_i        (wb_rd),
    .wb_result_i    (wb_result),
    .val_o          (w_fwd_a)
  );

  fwd_mux #(.WIDTH(WIDTH), .RA(RA)) u_fwd_b (
    .reg_i          (rt_q),
    .regval_i       (rd2_q),
    .mem_regwrite_i (mem_regwrite),
    .mem_rd_i       (mem_rd),
    .mem_result_i   (mem_result),
    .wb_regwrite_i  (wb_regwrite),
    .wb_rd_i        (wb_rd),
    .wb_result_i    (wb_result),
    .val_o          (w_fwd_b)
  );

  assign SrcA          = w_fwd_a;
  assign SrcB          = w_ex_alusrc ? imm_q : w_fwd_b;
  assign ex_store_data = w_fwd_b;
  assign ALUcon        = alucon_q;
  assign ex_wreg       = wreg_q;
  assign ex_ctrl       = valid_q ? ctrl_q[CTRL_Q_W-1:1] : 4'b0000;
  assign ex_valid      = valid_q;
  assign hazard_stall  = w_hazard;

endmodule : id_ex_stage
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_stage
// Purpose  : Self-checking bench for id_ex_stage. A reference model holds the
//            instruction currently in EX as a plain record and derives every
//            expected output from it and from the live forwarding inputs.
// Revision : 1.0  initial release
// ============================================================================
module tb_id_ex_stage;

  localparam int WIDTH = 32;
  localparam int RA    = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] id_rd1, id_rd2, id_imm;
  logic [RA-1:0]    id_rs, id_rt, id_rd;
  logic [3:0]       id_alucon;
  logic [5:0]       id_ctrl;
  logic             id_valid, stall, flush;
  logic             mem_regwrite, wb_regwrite;
  logic [RA-1:0]    mem_rd, wb_rd;
  logic [WIDTH-1:0] mem_result, wb_result;
  logic [WIDTH-1:0] SrcA, SrcB, ex_store_data;
  logic [3:0]       ALUcon, ex_ctrl;
  logic [RA-1:0]    ex_wreg;
  logic             ex_valid, hazard_stall;

  always #5 clk = ~clk;

  id_ex_stage #(.WIDTH(WIDTH), .RA(RA)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_alucon(id_alucon), .id_ctrl(id_ctrl), .id_valid(id_valid),
    .stall(stall), .flush(flush),
    .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_result(wb_result),
    .SrcA(SrcA), .SrcB(SrcB), .ALUcon(ALUcon), .ex_store_data(ex_store_data),
    .ex_wreg(ex_wreg), .ex_ctrl(ex_ctrl), .ex_valid(ex_valid),
    .hazard_stall(hazard_stall)
  );

  // Instruction sitting in EX, as the bench understands it.
  typedef struct {
    logic [31:0] rd1, rd2, imm;
    int          rs, rt, wreg;
    logic [3:0]  alu;
    bit          regwrite, memread, memwrite, memtoreg, alusrc;
    bit          valid;
  } ex_t;

  ex_t mdl;
  int  n_vec = 0;
  int  n_err = 0;

  // control bundle helpers: {regwrite, memread, memwrite, memtoreg, alusrc, regdst}
  localparam logic [5:0] C_ALU  = 6'b100001;  // R-type add
  localparam logic [5:0] C_LW   = 6'b110110;
  localparam logic [5:0] C_ADDI = 6'b100010;
  localparam logic [5:0] C_SW   = 6'b001010;

  function automatic ex_t bubble();
    ex_t b;
    b.rd1 = 0; b.rd2 = 0; b.imm = 0; b.rs = 0; b.rt = 0; b.wreg = 0; b.alu = 0;
    b.regwrite = 0; b.memread = 0; b.memwrite = 0; b.memtoreg = 0; b.alusrc = 0;
    b.valid = 0;
    return b;
  endfunction

  function automatic ex_t from_id();
    ex_t e;
    e.rd1 = id_rd1; e.rd2 = id_rd2; e.imm = id_imm;
    e.rs = int'(id_rs); e.rt = int'(id_rt);
    e.wreg = id_ctrl[0] ? int'(id_rd) : int'(id_rt);
    e.alu = id_alucon;
    e.regwrite = id_ctrl[5]; e.memread = id_ctrl[4]; e.memwrite = id_ctrl[3];
    e.memtoreg = id_ctrl[2]; e.alusrc = id_ctrl[1];
    e.valid = id_valid;
    return e;
  endfunction

  // Newest value of architectural register r as seen from EX.
  function automatic logic [31:0] newest(int r, logic [31:0] from_rf);
    if (r == 0) return from_rf;
    if (mem_regwrite && int'(mem_rd) == r) return mem_result;
    if (wb_regwrite && int'(wb_rd) == r) return wb_result;
    return from_rf;
  endfunction

  function automatic bit exp_hazard();
    bit uses_rs, uses_rt;
    if (!(mdl.valid && mdl.memread && id_valid) || mdl.wreg == 0) return 0;
    uses_rs = (int'(id_rs) == mdl.wreg);
    uses_rt = (int'(id_rt) == mdl.wreg) && !id_ctrl[1];
    return uses_rs || uses_rt;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] fa, fb;
    fa = newest(mdl.rs, mdl.rd1);
    fb = newest(mdl.rt, mdl.rd2);
    check({tag, ".SrcA"},   SrcA, fa);
    check({tag, ".SrcB"},   SrcB, mdl.alusrc ? mdl.imm : fb);
    check({tag, ".store"},  ex_store_data, fb);
    check({tag, ".ALUcon"}, {28'd0, ALUcon}, {28'd0, mdl.alu});
    check({tag, ".wreg"},   {27'd0, ex_wreg}, 32'(mdl.wreg));
    check({tag, ".ctrl"},   {28'd0, ex_ctrl},
          mdl.valid ? {28'd0, mdl.regwrite, mdl.memread, mdl.memwrite, mdl.memtoreg} : 32'd0);
    check({tag, ".valid"},  {31'd0, ex_valid}, {31'd0, mdl.valid});
    check({tag, ".hazard"}, {31'd0, hazard_stall}, {31'd0, exp_hazard()});
  endtask

  // Advance one clock; model follows the update priority flush > stall > hazard > load.
  task automatic step();
    ex_t nxt;
    if (!rst_n)            nxt = bubble();
    else if (flush)        nxt = bubble();
    else if (stall)        nxt = mdl;
    else if (exp_hazard()) nxt = bubble();
    else                   nxt = from_id();
    @(posedge clk);
    #1;
    mdl = nxt;
  endtask

  task automatic set_id(input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
                        input int rs, input int rt, input int rd,
                        input logic [3:0] alu, input logic [5:0] c, input logic v);
    id_rd1 = r1; id_rd2 = r2; id_imm = im;
    id_rs = RA'(rs); id_rt = RA'(rt); id_rd = RA'(rd);
    id_alucon = alu; id_ctrl = c; id_valid = v;
  endtask

  task automatic no_fwd();
    mem_regwrite = 0; mem_rd = 0; mem_result = 0;
    wb_regwrite = 0; wb_rd = 0; wb_result = 0;
  endtask

  task automatic rand_id();
    set_id($urandom, $urandom, $urandom, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
           int'($urandom_range(0, 7)), 4'($urandom), 6'($urandom), 1'($urandom));
  endtask

  initial begin
    mdl = bubble();
    stall = 0; flush = 0; no_fwd();
    // Reset with arbitrary ID inputs
    rst_n = 0;
    rand_id();
    id_valid = 1;
    step(); step();
    #1 check_all("reset");
    check("reset.SrcA0", SrcA, 32'd0);
    rst_n = 1;
    #1 check("reset.valid0", {31'd0, ex_valid}, 32'd0);

    // Plain capture
    set_id(32'h19, 32'h64, 32'h0, 1, 2, 4, 4'b0000, C_ALU, 1);
    step();
    #1 check_all("plain");
    check("plain.SrcA_c", SrcA, 32'h19);
    check("plain.SrcB_c", SrcB, 32'h64);

    // Forwarding: MEM, then MEM beats WB, then r0 never forwards
    set_id(32'h1111, 32'h2, 32'h0, 3, 6, 8, 4'b0010, C_ALU, 1);
    step();
    mem_regwrite = 1; mem_rd = 3; mem_result = 32'hA0A0;
    #1 check_all("fwd_mem");
    check("fwd_mem.SrcA_c", SrcA, 32'hA0A0);
    wb_regwrite = 1; wb_rd = 3; wb_result = 32'h5F5F;
    #1 check_all("fwd_prio");
    check("fwd_prio.SrcA_c", SrcA, 32'hA0A0);
    mem_rd = 4;
    #1 check("fwd_wb.SrcA_c", SrcA, 32'h5F5F);
    set_id(32'h77, 32'h2, 32'h0, 0, 6, 8, 4'b0010, C_ALU, 1);
    step();
    mem_rd = 0; wb_rd = 0;
    #1 check_all("fwd_r0");
    check("fwd_r0.SrcA_c", SrcA, 32'h77);
    no_fwd();

    // Load-use: lw r5 in EX, dependent add in ID
    set_id(32'h100, 32'h0, 32'h8, 2, 5, 0, 4'b0010, C_LW, 1);
    step();
    set_id(32'h0, 32'h9, 32'h0, 5, 1, 7, 4'b0010, C_ALU, 1);
    #1 check_all("lu.detect");
    check("lu.hazard_c", {31'd0, hazard_stall}, 32'd1);
    mem_regwrite = 1; mem_rd = 5; mem_result = 32'h108;
    step();
    #1 check_all("lu.bubble");
    check("lu.valid_c", {31'd0, ex_valid}, 32'd0);
    check("lu.hz_gone", {31'd0, hazard_stall}, 32'd0);
    mem_regwrite = 0; wb_regwrite = 1; wb_rd = 5; wb_result = 32'hBEEF;
    step();
    #1 check_all("lu.capture");
    check("lu.SrcA_c", SrcA, 32'hBEEF);
    no_fwd();

    // Immediate operand with forwarded store data
    set_id(32'h4, 32'h5, 32'hFFFFFFF6, 1, 7, 0, 4'b0010, C_SW, 1);
    step();
    mem_regwrite = 1; mem_rd = 7; mem_result = 32'h2222;
    #1 check_all("imm");
    check("imm.SrcB_c", SrcB, 32'hFFFFFFF6);
    check("imm.store_c", ex_store_data, 32'h2222);
    no_fwd();

    // flush + stall together -> bubble
    set_id(32'hAB, 32'hCD, 32'h1, 1, 2, 3, 4'b0110, C_ALU, 1);
    stall = 1; flush = 1;
    step();
    stall = 0; flush = 0;
    #1 check_all("flush_stall");
    check("flush_stall.valid_c", {31'd0, ex_valid}, 32'd0);
    step();
    // stall alone holds for 3 cycles while ID churns
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      rand_id();
      step();
      #1 check_all("hold");
      check("hold.SrcA_c", SrcA, 32'hAB);
    end
    stall = 0;

    // stall + hazard: hold, hazard still flagged
    set_id(32'h300, 32'h0, 32'h4, 2, 9, 0, 4'b0010, C_LW, 1);
    step();
    set_id(32'h0, 32'h0, 32'h0, 9, 9, 10, 4'b0010, C_ALU, 1);
    stall = 1;
    step();
    #1 check_all("stall_hz");
    check("stall_hz.hz_c", {31'd0, hazard_stall}, 32'd1);
    check("stall_hz.valid_c", {31'd0, ex_valid}, 32'd1);
    // reset mid-stall discards the held load
    #2 rst_n = 0;
    mdl = bubble();
    #1 check_all("rst_mid");
    step();
    rst_n = 1; stall = 0;

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      rand_id();
      stall = ($urandom_range(0, 9) == 0);
      flush = ($urandom_range(0, 11) == 0);
      mem_regwrite = 1'($urandom); mem_rd = RA'($urandom_range(0, 7)); mem_result = $urandom;
      wb_regwrite  = 1'($urandom); wb_rd  = RA'($urandom_range(0, 7)); wb_result  = $urandom;
      #1 check_all("rand");
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_id_ex_stage
`default_nettype wire
